sync_fifo_flags: RTL and testbench

- Single-clock, parametrised FIFO. Generalises the existing write/read FIFO with:
  - configurable depth and width;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - fill count, programmable almost-full/almost-empty thresholds;
  - sticky overflow/underflow error flags.
- Sits between same-clock producer/consumer stages.
- Serves as the buffer wherever clock-domain crossing is not required.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/sync_fifo_ram.sv | 28 ++
 rtl/sync_fifo_flags.sv | 120 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO family.
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   // Pointer width for a power-of-two depth; never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Occupancy needs one extra bit so that DEPTH itself is representable.
   function automatic int count_width(input int depth);
      return ptr_width(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH simple dual-port storage: one clocked write port, one asynchronous read port.
module sync_fifo_ram
   import fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int AW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the array has no reset; an emptied FIFO is defined by its pointers and count, not its contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost-full/almost-empty thresholds, sticky error flags and optional FWFT reads.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int FWFT      = FIFO_STD,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        w_en,
   input  logic [WIDTH-1:0]            data_in,
   input  logic                        rd_en,
   input  logic                        clr_err,
   output logic [WIDTH-1:0]            data_out,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             rd_ok, wr_ok;
   logic [WIDTH-1:0] ram_rdata;

   sync_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (PW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));

   // NOTE: every variable gets a default at the top so no path through the block can infer a latch.
   always_comb begin
      rd_ok       = rd_en & ~empty;
      wr_ok       = w_en & (~full | rd_ok);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      dout_d      = dout_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      // At full with a simultaneous write, the read sees the old word because the array updates at the edge.
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         dout_d   = ram_rdata;
      end

      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Clear first so that a new error in the same cycle wins.
      if (clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (w_en & ~wr_ok) begin
         overflow_d = 1'b1;
      end
      if (rd_en & ~rd_ok) begin
         underflow_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         dout_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         dout_q      <= dout_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign data_out  = (FWFT == FIFO_FWFT) ? ram_rdata : dout_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: a standard-read instance and an FWFT instance on one clock.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       w_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [7:0] data_in = '0, data_out;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] count;

   logic       f_w_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
   logic [7:0] f_data_in = '0, f_data_out;
   logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
   logic [3:0] f_count;

   int total = 0;
   int bad   = 0;

   // Reference model of the standard instance
   logic [7:0] model_q[$];
   logic [7:0] exp_q[$];
   int         m_count;
   bit         m_ovf, m_udf;
   logic [7:0] fwft_q[$];

   logic [7:0] fill_vals [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};

   sync_fifo_flags #(.DEPTH(8), .WIDTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_std (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
      .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_flags #(.DEPTH(8), .WIDTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_fwft (
      .clk(clk), .rst(rst), .w_en(f_w_en), .data_in(f_data_in), .rd_en(f_rd_en), .clr_err(f_clr_err),
      .data_out(f_data_out), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
      .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Drive one cycle on the standard instance and advance the model; read results go to exp_q.
   task automatic std_cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
      bit rd_ok, wr_ok;
      w_en = w; data_in = d; rd_en = r; clr_err = c;
      rd_ok = r && (m_count != 0);
      wr_ok = w && ((m_count != 8) || rd_ok);
      if (rd_ok) exp_q.push_back(model_q.pop_front());
      if (wr_ok) model_q.push_back(d);
      m_count = model_q.size();
      if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_udf = 1'b1;
      @(posedge clk); #1;
      w_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
   endtask

   task automatic fwft_cycle(input bit w, input logic [7:0] d, input bit r);
      f_w_en = w; f_data_in = d; f_rd_en = r;
      if (r && fwft_q.size() != 0) void'(fwft_q.pop_front());
      if (w) fwft_q.push_back(d);
      @(posedge clk); #1;
      f_w_en = 1'b0; f_rd_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_q.delete(); exp_q.delete(); fwft_q.delete();
      m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
         bad++; $display("FAIL reset_flags: got e/f/ae/af=%b want 1010", {empty, full, almost_empty, almost_full}); end
      total++; if ({overflow, underflow} !== 2'b00) begin
         bad++; $display("FAIL reset_err: got %b want 00", {overflow, underflow}); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", data_out); end
      total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL reset_fwft_empty: got %b want 1", f_empty); end
      rst = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         std_cycle(1'b1, fill_vals[i], 1'b0, 1'b0);
         total++; if (count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
         total++; if (almost_empty !== (i + 1 <= 2)) begin bad++; $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, (i + 1 <= 2)); end
         total++; if (almost_full !== (i + 1 >= 6)) begin bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= 6)); end
         total++; if (full !== (i == 7) || empty !== 1'b0) begin bad++; $display("FAIL fill_fe[%0d]: got f=%b e=%b want f=%b e=0", i, full, empty, (i == 7)); end
         total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf[%0d]: got %b want 0", i, overflow); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp;
      std_cycle(1'b1, 8'h99, 1'b0, 1'b0);
      total++; if (count !== 4'd8 || full !== 1'b1) begin bad++; $display("FAIL ovf_count: got %0d full=%b want 8 full=1", count, full); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      for (int i = 0; i < 8; i++) begin
         std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         exp = exp_q.pop_front();
         total++; if (data_out !== exp) begin bad++; $display("FAIL ovf_read_sb[%0d]: got %h want %h", i, data_out, exp); end
         total++; if (data_out !== fill_vals[i]) begin bad++; $display("FAIL ovf_read_order[%0d]: got %h want %h", i, data_out, fill_vals[i]); end
      end
      total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL ovf_drained: got e=%b cnt=%0d want e=1 cnt=0", empty, count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_underflow();
      std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_flag: got %b want 1", underflow); end
      total++; if (data_out !== 8'h18) begin bad++; $display("FAIL udf_hold: got %h want 18", data_out); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL udf_count: got %0d want 0", count); end
      std_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL clr_err: got %b want 00", {overflow, underflow}); end
      // An error in the same cycle as clr_err must survive.
      std_cycle(1'b0, 8'h00, 1'b1, 1'b1);
      total++; if (underflow !== m_udf || m_udf !== 1'b1) begin bad++; $display("FAIL clr_priority: got %b want 1", underflow); end
      std_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL clr_again: got %b want 0", underflow); end
   endtask

   task automatic test_boundaries();
      logic [7:0] exp;
      for (int i = 0; i < 8; i++) std_cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      std_cycle(1'b1, 8'h55, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      total++; if (count !== 4'd8 || overflow !== 1'b0) begin bad++; $display("FAIL full_rw_count: got cnt=%0d ovf=%b want 8/0", count, overflow); end
      total++; if (data_out !== exp || data_out !== 8'h10) begin bad++; $display("FAIL full_rw_oldest: got %h want 10", data_out); end
      for (int i = 0; i < 8; i++) begin
         std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         exp = exp_q.pop_front();
         total++; if (data_out !== exp) begin bad++; $display("FAIL full_rw_drain[%0d]: got %h want %h", i, data_out, exp); end
      end
      total++; if (data_out !== 8'h55) begin bad++; $display("FAIL full_rw_last: got %h want 55", data_out); end
      std_cycle(1'b1, 8'h66, 1'b1, 1'b0);
      total++; if (count !== 4'd1 || underflow !== 1'b1) begin bad++; $display("FAIL empty_rw: got cnt=%0d udf=%b want 1/1", count, underflow); end
      std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      total++; if (data_out !== exp || data_out !== 8'h66) begin bad++; $display("FAIL empty_rw_read: got %h want 66", data_out); end
      std_cycle(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_wrap();
      logic [7:0] exp;
      logic [7:0] d;
      for (int i = 0; i < 3; i++) std_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom_range(0, 255));
         std_cycle(1'b1, d, 1'b0, 1'b0);
         total++; if (count > 4'd8 || count !== 4'(m_count)) begin bad++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, count, m_count); end
         std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         exp = exp_q.pop_front();
         total++; if (data_out !== exp) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, data_out, exp); end
      end
      for (int i = 0; i < 3; i++) begin
         std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         exp = exp_q.pop_front();
         total++; if (data_out !== exp) begin bad++; $display("FAIL wrap_drain[%0d]: got %h want %h", i, data_out, exp); end
      end
      total++; if (empty !== 1'b1 || {overflow, underflow} !== 2'b00) begin
         bad++; $display("FAIL wrap_end: got e=%b err=%b want e=1 err=00", empty, {overflow, underflow}); end
   endtask

   task automatic test_fwft();
      fwft_cycle(1'b1, 8'h3C, 1'b0);
      total++; if (f_empty !== 1'b0) begin bad++; $display("FAIL fwft_first_empty: got %b want 0", f_empty); end
      total++; if (f_data_out !== fwft_q[0] || f_data_out !== 8'h3C) begin bad++; $display("FAIL fwft_first_data: got %h want 3C", f_data_out); end
      fwft_cycle(1'b0, 8'h00, 1'b1);
      total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL fwft_pop_empty: got %b want 1", f_empty); end
      fwft_cycle(1'b1, 8'h4D, 1'b0);
      total++; if (f_data_out !== fwft_q[0]) begin bad++; $display("FAIL fwft_4d: got %h want %h", f_data_out, fwft_q[0]); end
      fwft_cycle(1'b1, 8'h5E, 1'b0);
      total++; if (f_data_out !== 8'h4D || f_count !== 4'd2) begin bad++; $display("FAIL fwft_head_hold: got %h cnt=%0d want 4D cnt=2", f_data_out, f_count); end
      fwft_cycle(1'b0, 8'h00, 1'b1);
      total++; if (f_data_out !== fwft_q[0] || f_data_out !== 8'h5E) begin bad++; $display("FAIL fwft_next: got %h want 5E", f_data_out); end
      fwft_cycle(1'b0, 8'h00, 1'b1);
      total++; if (f_empty !== 1'b1 || f_underflow !== 1'b0) begin bad++; $display("FAIL fwft_drained: got e=%b udf=%b want 1/0", f_empty, f_underflow); end
   endtask

   task automatic test_mid_reset();
      logic [7:0] exp;
      std_cycle(1'b1, 8'h2A, 1'b0, 1'b0);
      std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      exp = exp_q.pop_front();
      total++; if (data_out !== exp) begin bad++; $display("FAIL mid_pre_read: got %h want %h", data_out, exp); end
      for (int i = 0; i < 5; i++) std_cycle(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
      total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_pre_count: got %0d want 5", count); end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      model_q.delete(); m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
      total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_reset: got cnt=%0d e=%b want 0/1", count, empty); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_reset_dout: got %h want 00", data_out); end
      std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++; if (underflow !== 1'b1 || data_out !== 8'h00) begin bad++; $display("FAIL mid_reset_discard: got udf=%b dout=%h want 1/00", underflow, data_out); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_underflow();
      test_boundaries();
      test_wrap();
      test_fwft();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
